audio_mix_i2s_tx: RTL and testbench
===================================

AUDIO_MIX_I2S_TX -- requirements
Module: audio_mix_i2s_tx

Interface
REQ-001 The block SHALL have parameter NUM_CH, default 2: number of mixed voices (1..8).
REQ-002 The block SHALL have parameter SAMPLE_W, default 24: signed sample width (8..31).
REQ-003 The block SHALL have parameter VOL_W, default 4: master volume width.
REQ-004 The block SHALL have parameter BCLK_DIV, default 4: clk cycles per bclk half-period (>=2).
REQ-005 The block SHALL have port clk, input, 1 bit: single clock for all logic; one clock, no other clock domains.
REQ-006 The block SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-007 The block SHALL have port in_valid, input, 1 bit: the mix frame is valid.
REQ-008 The block SHALL have port in_ready, output, 1 bit: the block accepts a frame.
REQ-009 The block SHALL have port in_left, input, NUM_CH*SAMPLE_W bits: packed signed left samples, voice 0 in the LSBs.
REQ-010 The block SHALL have port in_right, input, NUM_CH*SAMPLE_W bits: packed signed right samples, voice 0 in the LSBs.
REQ-011 The block SHALL have port master_vol, input, VOL_W bits: unsigned gain in units of 1/2^VOL_W.
REQ-012 The block SHALL have port mute, input, 1 bit: force the output to silence.
REQ-013 The block SHALL have port audio_I2S_bclk, output, 1 bit: bit clock.
REQ-014 The block SHALL have port audio_I2S_pblrc, output, 1 bit: word select; 0 = left, 1 = right.
REQ-015 The block SHALL have port audio_I2S_pbdat, output, 1 bit: serial data.
REQ-016 The block SHALL have port underrun_cnt, output, 16 bits: number of frames transmitted without new data, saturating.

Function
REQ-017 A frame SHALL be accepted on any clk edge where in_valid && in_ready; master_vol and mute SHALL be sampled on that same edge.
REQ-018 in_ready SHALL be registered and SHALL equal NOT(pipeline busy OR pending full); a one-entry pending buffer SHALL hold the mixed frame.
REQ-019 The mix SHALL take 2 cycles and set pending on the 2nd edge after acceptance:
- stage 1: signed sum per side, width SAMPLE_W+clog2(NUM_CH)+1;
- stage 2: multiply by master_vol, arithmetic shift right by VOL_W, saturate to SAMPLE_W signed.
REQ-020 A frame with mute=1 or master_vol=0 at acceptance SHALL mix to exactly 0 on both sides.
REQ-021 Bit clock: a counter div_cnt SHALL run 0..BCLK_DIV-1, and bclk SHALL toggle when div_cnt=BCLK_DIV-1; the bclk period SHALL be 2*BCLK_DIV clk cycles.
REQ-022 A 6-bit bit counter SHALL advance on each bclk falling toggle and wrap 63->0; pblrc and pbdat SHALL change only on the falling toggle.
REQ-023 Slot timing:
- pblrc = bit_cnt[5];
- slot bit 0 SHALL carry 0 (I2S one-bit delay);
- slot bits 1..SAMPLE_W SHALL carry the sample, MSB first;
- the remaining bits SHALL carry 0.
REQ-024 At the falling toggle where bit_cnt wraps to 0:
- if pending=1, the left and right shift registers SHALL load the pending frame and pending SHALL clear;
- otherwise both SHALL load 0 and underrun_cnt SHALL increment, saturating at 0xFFFF.
REQ-025 If the pipeline sets pending on the same edge as a frame load, the load SHALL see pending=0 (underrun), and the new frame SHALL go out in the next frame.
REQ-026 A change of master_vol or mute SHALL NOT alter a frame that was already accepted.

Reset
REQ-027 While rst=1, all of the following SHALL hold on the next edge:
- bclk=0, pblrc=0, pbdat=0;
- div_cnt=0, bit_cnt=0;
- pending=0, pipeline empty;
- in_ready=0, then 1 on the first cycle after release;
- underrun_cnt=0;
- shift registers=0.
REQ-028 A reset mid-frame SHALL discard the accepted, pipelined and pending data, and SHALL restart the frame at bit_cnt=0 with no partial word.

Verification
REQ-029 With NUM_CH=2, SAMPLE_W=16, BCLK_DIV=2: left voices 0x1000 and 0x1000, vol=8 -> serialized left word 0x1000; right voices 0x0000 and 0x0001, vol=15 -> right word 0x0000.
REQ-030 Left voices 0x7FFF and 0x7FFF with vol=15 -> 0x7FFF (saturated); voices 0x8000 and 0x8000 with vol=15 -> 0x8000.
REQ-031 No in_valid after reset for 3 frames -> pbdat constant 0, underrun_cnt=3, pblrc period 256 clk, bclk period 4 clk.
REQ-032 Hold in_valid=1 continuously -> exactly one acceptance per 64 bclks after the first frame, in_ready low while pending=1, and no underrun after the first frame.
REQ-033 mute=1 at acceptance, then mute=0 next cycle -> that frame transmits 0 and the following frame transmits the mixed value.
REQ-034 Assert rst for 1 cycle at bit_cnt=20 of the left slot -> all outputs 0 on the next edge, underrun_cnt=0, and the next frame starts cleanly at bit 0.

Source files
------------

// File: rtl/audio_mix_i2s_tx.sv
// Multi-voice audio mixer with master volume, feeding a 64-bit-frame I2S transmitter.
// Frames pass a two-stage mix pipeline into a one-entry pending buffer loaded at frame start.
module audio_mix_i2s_tx #(
  parameter int unsigned NUM_CH   = 2,
  parameter int unsigned SAMPLE_W = 24,
  parameter int unsigned VOL_W    = 4,
  parameter int unsigned BCLK_DIV = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [NUM_CH*SAMPLE_W-1:0] in_left,
  input  logic [NUM_CH*SAMPLE_W-1:0] in_right,
  input  logic [VOL_W-1:0]           master_vol,
  input  logic                       mute,
  output logic                       audio_I2S_bclk,
  output logic                       audio_I2S_pblrc,
  output logic                       audio_I2S_pbdat,
  output logic [15:0]                underrun_cnt
);
  localparam int unsigned SUM_W  = SAMPLE_W + $clog2(NUM_CH) + 1;
  localparam int unsigned PROD_W = SUM_W + VOL_W + 1;
  localparam int unsigned DIV_W  = $clog2(BCLK_DIV);
  localparam logic signed [PROD_W-1:0] SAT_MAX = PROD_W'(2 ** (SAMPLE_W - 1) - 1);
  localparam logic signed [PROD_W-1:0] SAT_MIN = PROD_W'(-(2 ** (SAMPLE_W - 1)));

  function automatic logic signed [SUM_W-1:0] f_sum(input logic [NUM_CH*SAMPLE_W-1:0] v);
    logic signed [SUM_W-1:0] acc;
    acc = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      acc = acc + SUM_W'($signed(v[i*SAMPLE_W +: SAMPLE_W]));
    end
    return acc;
  endfunction

  function automatic logic [SAMPLE_W-1:0] f_scale(input logic signed [SUM_W-1:0] s,
                                                  input logic [VOL_W-1:0] vol);
    logic signed [PROD_W-1:0] prod;
    prod = PROD_W'(s) * PROD_W'($signed({1'b0, vol}));
    prod = prod >>> VOL_W;
    if (prod > SAT_MAX) return SAT_MAX[SAMPLE_W-1:0];
    if (prod < SAT_MIN) return SAT_MIN[SAMPLE_W-1:0];
    return prod[SAMPLE_W-1:0];
  endfunction

  logic                          r_ready, r_cap_v, r_s1_v, r_pending;
  logic [NUM_CH*SAMPLE_W-1:0]    r_in_l, r_in_r;
  logic [VOL_W-1:0]              r_vol, r_vol1;
  logic signed [SUM_W-1:0]       r_sum_l, r_sum_r;
  logic [SAMPLE_W-1:0]           r_pend_l, r_pend_r, r_sh_l, r_sh_r;
  logic [DIV_W-1:0]              r_div;
  logic                          r_bclk, r_dat;
  logic [5:0]                    r_bit;
  logic [15:0]                   r_underrun;

  logic       w_acc, w_pending_d, w_ready_d, w_tick, w_fall, w_load, w_in_word;
  logic [5:0] w_bit_nx;

  assign w_acc       = in_valid && r_ready;
  assign w_tick      = (r_div == DIV_W'(BCLK_DIV - 1));
  assign w_fall      = w_tick && r_bclk;
  assign w_bit_nx    = r_bit + 6'd1;
  assign w_load      = w_fall && (w_bit_nx == 6'd0);
  assign w_in_word   = (w_bit_nx[4:0] != 5'd0) && (w_bit_nx[4:0] <= 5'(SAMPLE_W));
  // A frame landing on the load edge is not seen by that load; it waits a frame.
  assign w_pending_d = r_s1_v || (r_pending && !w_load);
  assign w_ready_d   = !(w_acc || r_cap_v || w_pending_d);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_ready    <= 1'b0;
      r_cap_v    <= 1'b0;
      r_s1_v     <= 1'b0;
      r_pending  <= 1'b0;
      r_in_l     <= '0;
      r_in_r     <= '0;
      r_vol      <= '0;
      r_vol1     <= '0;
      r_sum_l    <= '0;
      r_sum_r    <= '0;
      r_pend_l   <= '0;
      r_pend_r   <= '0;
      r_sh_l     <= '0;
      r_sh_r     <= '0;
      r_div      <= '0;
      r_bclk     <= 1'b0;
      r_dat      <= 1'b0;
      r_bit      <= '0;
      r_underrun <= '0;
    end else begin
      r_ready   <= w_ready_d;
      r_cap_v   <= w_acc;
      r_s1_v    <= r_cap_v;
      r_pending <= w_pending_d;
      if (w_acc) begin
        r_in_l <= in_left;
        r_in_r <= in_right;
        // Mute is folded into the gain so it travels with the frame.
        r_vol  <= mute ? '0 : master_vol;
      end
      if (r_cap_v) begin
        r_sum_l <= f_sum(r_in_l);
        r_sum_r <= f_sum(r_in_r);
        r_vol1  <= r_vol;
      end
      if (r_s1_v) begin
        r_pend_l <= f_scale(r_sum_l, r_vol1);
        r_pend_r <= f_scale(r_sum_r, r_vol1);
      end

      if (w_tick) begin
        r_div  <= '0;
        r_bclk <= ~r_bclk;
      end else begin
        r_div <= r_div + DIV_W'(1);
      end

      if (w_fall) begin
        r_bit <= w_bit_nx;
        if (w_load) begin
          r_dat <= 1'b0;
          if (r_pending) begin
            r_sh_l <= r_pend_l;
            r_sh_r <= r_pend_r;
          end else begin
            r_sh_l <= '0;
            r_sh_r <= '0;
            if (r_underrun != 16'hFFFF) r_underrun <= r_underrun + 16'd1;
          end
        end else if (w_in_word) begin
          if (w_bit_nx[5]) begin
            r_dat  <= r_sh_r[SAMPLE_W-1];
            r_sh_r <= r_sh_r << 1;
          end else begin
            r_dat  <= r_sh_l[SAMPLE_W-1];
            r_sh_l <= r_sh_l << 1;
          end
        end else begin
          r_dat <= 1'b0;
        end
      end
    end
  end

  assign in_ready        = r_ready;
  assign audio_I2S_bclk  = r_bclk;
  assign audio_I2S_pblrc = r_bit[5];
  assign audio_I2S_pbdat = r_dat;
  assign underrun_cnt    = r_underrun;

endmodule

// File: tb/tb_audio_mix_i2s_tx.sv
// Bench for audio_mix_i2s_tx: vector table of mix frames scored against a deserializing monitor,
// plus idle, load-race and mid-frame reset sequences.
module tb_audio_mix_i2s_tx;
  localparam int unsigned NUM_CH    = 2;
  localparam int unsigned SAMPLE_W  = 16;
  localparam int unsigned VOL_W     = 4;
  localparam int unsigned BCLK_DIV  = 2;
  localparam int          FRAME_CLK = 64 * 2 * BCLK_DIV;
  localparam int          NV        = 9;

  typedef struct {
    logic [15:0] l0, l1, r0, r1;
    logic [3:0]  vol;
    logic        mute;
    logic [15:0] el, er;
  } vec_t;

  typedef struct {
    int          wnd;
    logic [15:0] l, r;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] in_left = '0;
  logic [31:0] in_right = '0;
  logic [3:0]  master_vol = '0;
  logic        mute = 1'b0;
  logic        bclk, lrc, dat;
  logic [15:0] underrun;

  int   errors = 0;
  int   checks = 0;
  int   cyc = 0;
  int   acc_cyc = 0;
  int   acc_wait = 0;
  exp_t sb[$];
  vec_t tbl[NV];

  audio_mix_i2s_tx #(
    .NUM_CH  (NUM_CH),
    .SAMPLE_W(SAMPLE_W),
    .VOL_W   (VOL_W),
    .BCLK_DIV(BCLK_DIV)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .in_valid       (in_valid),
    .in_ready       (in_ready),
    .in_left        (in_left),
    .in_right       (in_right),
    .master_vol     (master_vol),
    .mute           (mute),
    .audio_I2S_bclk (bclk),
    .audio_I2S_pblrc(lrc),
    .audio_I2S_pbdat(dat),
    .underrun_cnt   (underrun)
  );

  always #5 clk = ~clk;

  // Edge number since the last reset edge.
  always @(posedge clk) begin
    if (rst) cyc <= 0;
    else     cyc <= cyc + 1;
  end

  task automatic check(input string name, input logic [39:0] act, input logic [39:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, req);
    end
  endtask

  int          mon_pos = -1;
  int          mon_wnd = 0;
  logic        mon_lrc = 1'b0;
  logic        mon_bclk = 1'b0;
  logic        mon_pad = 1'b0;
  logic [15:0] mon_word = '0;
  logic [15:0] mon_l = '0;

  task automatic frame_done();
    exp_t  e;
    string nm;
    e.wnd = mon_wnd;
    e.l   = '0;
    e.r   = '0;
    nm    = "idle_frame";
    while (sb.size() > 0 && sb[0].wnd < mon_wnd) begin
      checks++;
      errors++;
      $display("FAIL missed_frame: got no frame by window %0d, required one in window %0d",
               mon_wnd, sb[0].wnd);
      void'(sb.pop_front());
    end
    if (sb.size() > 0 && sb[0].wnd == mon_wnd) begin
      e  = sb.pop_front();
      nm = "mix_frame";
    end
    check(nm, {7'd0, mon_pad, mon_l, mon_word}, {8'd0, e.l, e.r});
    mon_pad = 1'b0;
  endtask

  // Receiver: samples on bclk rising, slot position restarts at each pblrc change.
  initial begin
    forever begin
      @(negedge clk);
      if (rst) begin
        mon_pos  = -1;
        mon_wnd  = 0;
        mon_lrc  = 1'b0;
        mon_bclk = 1'b0;
        mon_pad  = 1'b0;
      end else begin
        if (bclk && !mon_bclk) begin
          if (lrc != mon_lrc) begin
            mon_pos = 0;
            if (!lrc) mon_wnd++;
          end else begin
            mon_pos++;
          end
          mon_lrc = lrc;
          if (mon_pos >= 1 && mon_pos <= int'(SAMPLE_W)) mon_word = {mon_word[14:0], dat};
          else if (dat) mon_pad = 1'b1;
          if (mon_pos == int'(SAMPLE_W)) begin
            if (!lrc) mon_l = mon_word;
            else      frame_done();
          end
        end
        mon_bclk = bclk;
      end
    end
  end

  task automatic do_reset();
    rst      = 1'b1;
    in_valid = 1'b0;
    @(posedge clk); #1;
    sb.delete();
    check("reset_state", {20'd0, bclk, lrc, dat, in_ready, underrun}, 40'd0);
    rst = 1'b0;
    @(posedge clk); #1;
    check("ready_after_reset", {39'd0, in_ready}, 40'd1);
  endtask

  task automatic wait_cyc(input int n);
    while (cyc < n) begin
      @(posedge clk); #1;
    end
  endtask

  // Expected output window follows from acceptance edge: pending two edges later, then next load.
  task automatic send(input vec_t v, input bit keep, input string nm);
    int t;
    t          = 0;
    in_left    = {v.l1, v.l0};
    in_right   = {v.r1, v.r0};
    master_vol = v.vol;
    mute       = v.mute;
    in_valid   = 1'b1;
    while (!in_ready && t < 4 * FRAME_CLK) begin
      @(posedge clk); #1;
      t++;
    end
    acc_wait = t;
    if (!in_ready) begin
      checks++;
      errors++;
      $display("FAIL %s: in_ready got 0 after %0d cycles, required 1", nm, t);
    end else begin
      @(posedge clk); #1;
      acc_cyc = cyc;
      sb.push_back('{wnd: (cyc + 2) / FRAME_CLK + 1, l: v.el, r: v.er});
    end
    if (!keep) in_valid = 1'b0;
  endtask

  task automatic drain();
    int t;
    t = 0;
    while (sb.size() > 0 && t < 3 * FRAME_CLK) begin
      @(posedge clk); #1;
      t++;
    end
    check("drain", 40'(sb.size()), 40'd0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got no end of test, required finish");
    $fatal(1);
  end

  initial begin
    int   prev;
    int   last_b, per_b, last_l, per_l;
    logic pb, pl;

    tbl[0] = '{16'h1000, 16'h1000, 16'h0000, 16'h0001, 4'd8,  1'b0, 16'h1000, 16'h0000};
    tbl[1] = '{16'h1000, 16'h1000, 16'h0000, 16'h0001, 4'd15, 1'b0, 16'h1E00, 16'h0000};
    tbl[2] = '{16'h7FFF, 16'h7FFF, 16'h8000, 16'h8000, 4'd15, 1'b0, 16'h7FFF, 16'h8000};
    tbl[3] = '{16'h1000, 16'h1000, 16'h0000, 16'h0001, 4'd8,  1'b1, 16'h0000, 16'h0000};
    tbl[4] = '{16'h1000, 16'h1000, 16'h0000, 16'h0001, 4'd8,  1'b0, 16'h1000, 16'h0000};
    tbl[5] = '{16'h7FFF, 16'h7FFF, 16'h7FFF, 16'h8000, 4'd0,  1'b0, 16'h0000, 16'h0000};
    tbl[6] = '{16'hFFFF, 16'hFFFF, 16'h0100, 16'h0200, 4'd15, 1'b0, 16'hFFFE, 16'h02D0};
    tbl[7] = '{16'h4000, 16'h4000, 16'h8000, 16'h7FFF, 4'd1,  1'b0, 16'h0800, 16'hFFFF};
    tbl[8] = '{16'h1234, 16'h0000, 16'h4000, 16'h3FFF, 4'd15, 1'b0, 16'h1110, 16'h77FF};

    // Streaming table with in_valid held high throughout.
    do_reset();
    prev = 0;
    for (int i = 0; i < NV; i++) begin
      send(tbl[i], 1'b1, "table_accept");
      if (i == 0) check("first_accept", 40'(acc_cyc), 40'd2);
      if (i == 1) check("first_reload_accept", 40'(acc_cyc), 40'd257);
      if (i >= 2) begin
        check("accept_spacing", 40'(acc_cyc - prev), 40'(FRAME_CLK));
        check("ready_low_wait", 40'(acc_wait), 40'(FRAME_CLK - 1));
      end
      prev = acc_cyc;
    end
    in_valid = 1'b0;
    check("no_underrun_streaming", 40'(underrun), 40'd0);
    drain();

    // Idle after reset: silent frames, clock periods, underrun count.
    do_reset();
    last_b = -1; per_b = 0; last_l = -1; per_l = 0; pb = 1'b0; pl = 1'b0;
    while (cyc < 3 * FRAME_CLK + 4) begin
      @(posedge clk); #1;
      if (bclk && !pb) begin
        if (last_b >= 0) per_b = cyc - last_b;
        last_b = cyc;
      end
      if (lrc && !pl) begin
        if (last_l >= 0) per_l = cyc - last_l;
        last_l = cyc;
      end
      pb = bclk;
      pl = lrc;
    end
    check("bclk_period", 40'(per_b), 40'(2 * BCLK_DIV));
    check("pblrc_period", 40'(per_l), 40'(FRAME_CLK));
    check("underrun_idle3", 40'(underrun), 40'd3);

    // Pending set on the same edge as the frame load.
    do_reset();
    wait_cyc(253);
    send(tbl[1], 1'b0, "race_accept");
    check("race_accept_edge", 40'(acc_cyc), 40'd254);
    wait_cyc(300);
    check("race_underrun", 40'(underrun), 40'd1);
    drain();

    // Reset at bit 20 of the left slot while a frame is on the wire.
    do_reset();
    wait_cyc(300);
    check("underrun_pre_reset", 40'(underrun), 40'd1);
    send(tbl[0], 1'b0, "midreset_accept");
    wait_cyc(592);
    check("left_slot_before_reset", {39'd0, lrc}, 40'd0);
    do_reset();
    send(tbl[2], 1'b0, "post_reset_accept");
    drain();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
